alu_writeback: RTL
==================

# alu_writeback

Writeback stage directly downstream of the 8-bit ALU. Captures each ALU result and its carry/overflow/zero/negative flags into the accumulator and the flag register under per-field write enables. Keeps a sticky overflow bit and evaluates a registered branch condition from the updated flags. A single-entry valid/ready pipeline register separates the ALU from the control unit.

## Interface
- ACC_RESET, 8'h00, accumulator value after reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result and controls valid this cycle
- in_ready  out  1  stage can accept; combinational: !out_valid || out_ready
- alu_result  in  8  ALU result byte
- carry, overflow, zero, negative  in  1 each  ALU flags
- acc_we  in  1  write alu_result into accumulator on capture
- flag_we  in  4  per-flag write mask {C,V,Z,N} = bits [3:0]
- cond_sel  in  3  branch condition select, sampled on capture
- clr_sticky  in  1  clear sticky overflow (independent of handshake)
- out_valid  out  1  registered entry present
- out_ready  in  1  consumer accepts entry
- acc  out  8  accumulator
- flags  out  4  {C,V,Z,N}
- sticky_v  out  1  sticky overflow
- cond_true  out  1  registered condition result for current entry

## Operation
- Capture = in_valid && in_ready; drain = out_valid && out_ready.
- On capture:
  - acc <= alu_result if acc_we, else hold.
  - Each flag i <= its ALU input if flag_we[i], else hold.
  - cond_true is evaluated on the merged (post-write) flags.
  - out_valid <= 1.
- On drain without capture: out_valid <= 0. acc, flags and cond_true hold.
- Capture and drain in the same cycle: the new entry replaces the old one and out_valid stays 1. No bubble.
- Capture with acc_we=0 and flag_we=0 still produces an entry (condition-test only).
- cond_sel encoding:
  - 000: always
  - 001: Z
  - 010: !Z
  - 011: C
  - 100: !C
  - 101: N
  - 110: V
  - 111: N^V (signed less-than)
- sticky_v:
  - Sets on capture with flag_we[2]=1 and overflow=1.
  - Cleared by clr_sticky.
  - If set and clear occur in the same cycle, set wins.
- State (implicit FSM on out_valid):
  - EMPTY: out_valid=0. Moves to FULL on capture.
  - FULL: out_valid=1. Stays FULL on capture, or when out_ready=0. Moves to EMPTY on drain without capture.
- Inputs are ignored when in_valid=0, and when in_ready=0 (back-pressure). The ALU source must hold its data while stalled.

## Timing
- Reset (async assert, sync release at the next clk edge):
  - acc=ACC_RESET, flags=4'b0000, sticky_v=0, cond_true=0, out_valid=0.
  - in_ready=1 immediately, because it is combinational.
- Latency: capture at edge N gives updated acc, flags, cond_true and out_valid at edge N.
  - Visible from cycle N+1 onward.
- Throughput: one entry per cycle while out_ready=1.
- in_ready depends combinationally on out_ready only. There is no path from in_valid to in_ready.
- Reset mid-operation discards any held entry. No partial update is permitted.
- clr_sticky is registered, with one-cycle effect. It acts even while stalled.

## Test plan
- Reset with ACC_RESET=8'hA5: assert rst_n=0 mid-cycle.
  - Outputs change immediately to acc=A5, flags=0, out_valid=0, in_ready=1.
- Add 0x7F+0x01: alu_result=80, V=1, N=1, C=0, Z=0, acc_we=1, flag_we=F, cond_sel=111, out_ready=1.
  - Next cycle: acc=80, flags=4'b0101, sticky_v=1, cond_true=0 (N^V=0), out_valid=1.
- Subtract 5-5: result=00, Z=1, flag_we=4'b0010 (Z only), cond_sel=001.
  - Result: flags Z=1 with C/V/N unchanged, cond_true=1, acc=00.
- Back-pressure: out_ready=0 with out_valid=1, then present a new in_valid.
  - in_ready=0; acc, flags and entry are unchanged for 3 cycles.
  - Raise out_ready: the new entry is captured the same cycle the old one drains, and out_valid stays 1.
- Sticky race: capture with overflow=1, flag_we[2]=1 and clr_sticky=1 in the same cycle.
  - sticky_v=1. The next cycle with clr_sticky=1 and no set gives sticky_v=0.
- Condition-only entry: acc_we=0, flag_we=0, cond_sel=011 with C previously 1.
  - acc and flags hold, cond_true=1, out_valid=1.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback stage after the 8-bit ALU: accumulator, {C,V,Z,N} flags, sticky
// overflow and a registered branch condition behind a single-entry valid/ready register.
module alu_writeback #(
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] alu_result,
    input  logic       carry,
    input  logic       overflow,
    input  logic       zero,
    input  logic       negative,
    input  logic       acc_we,
    input  logic [3:0] flag_we,
    input  logic [2:0] cond_sel,
    input  logic       clr_sticky,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] acc,
    output logic [3:0] flags,
    output logic       sticky_v,
    output logic       cond_true
);

    // Handshake: capture = in_valid && in_ready, drain = out_valid && out_ready.
    // in_ready = !out_valid || out_ready, so a full entry can be replaced in
    // the cycle it drains and in_ready never depends on in_valid.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       capture;
    logic       drain;
    logic [3:0] alu_flags;
    logic [3:0] merged_flags;
    logic       cond_next;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign capture   = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    assign alu_flags    = {carry, overflow, zero, negative};
    assign merged_flags = (alu_flags & flag_we) | (flags & ~flag_we);

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (capture) state_next = FULL;
            FULL:    if (drain && !capture) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Condition is evaluated on the post-write flags: [3]=C [2]=V [1]=Z [0]=N.
    always_comb begin
        cond_next = 1'b0;
        case (cond_sel)
            3'b000: cond_next = 1'b1;
            3'b001: cond_next = merged_flags[1];
            3'b010: cond_next = !merged_flags[1];
            3'b011: cond_next = merged_flags[3];
            3'b100: cond_next = !merged_flags[3];
            3'b101: cond_next = merged_flags[0];
            3'b110: cond_next = merged_flags[2];
            3'b111: cond_next = merged_flags[0] ^ merged_flags[2];
            default: cond_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            acc       <= ACC_RESET;
            flags     <= 4'b0000;
            cond_true <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                if (acc_we) acc <= alu_result;
                flags     <= merged_flags;
                cond_true <= cond_next;
            end
        end
    end

    // A new overflow wins over a same-cycle clear; clear acts even when stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v <= 1'b0;
        end else if (capture && flag_we[2] && overflow) begin
            sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            sticky_v <= 1'b0;
        end
    end

endmodule
